// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith results plus an
// iterative radix-2 restoring divider that stalls the pipe and writes HI/LO.
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        annul_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] OP_AND  = 8'b00100100;
  localparam logic [7:0] OP_OR   = 8'b00100101;
  localparam logic [7:0] OP_XOR  = 8'b00100110;
  localparam logic [7:0] OP_NOR  = 8'b00100111;
  localparam logic [7:0] OP_SLL  = 8'b01111100;
  localparam logic [7:0] OP_SRL  = 8'b00000010;
  localparam logic [7:0] OP_SRA  = 8'b00000011;
  localparam logic [7:0] OP_ADDU = 8'b00100001;
  localparam logic [7:0] OP_SUBU = 8'b00100011;
  localparam logic [7:0] OP_SLT  = 8'b00101010;
  localparam logic [7:0] OP_SLTU = 8'b00101011;
  localparam logic [7:0] OP_DIV  = 8'b00011010;
  localparam logic [7:0] OP_DIVU = 8'b00011011;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVZERO,
    S_ON,
    S_DONE
  } div_state_t;

  logic        is_div;
  logic        is_sdiv;
  logic [4:0]  sh;
  logic [31:0] logic_res;
  logic [31:0] shift_res;
  logic [31:0] arith_res;
  logic [31:0] alu_res;

  assign is_sdiv = (aluop_i == OP_DIV);
  assign is_div  = is_sdiv || (aluop_i == OP_DIVU);
  assign sh      = reg1_i[4:0];

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      OP_AND:  logic_res = reg1_i & reg2_i;
      OP_OR:   logic_res = reg1_i | reg2_i;
      OP_XOR:  logic_res = reg1_i ^ reg2_i;
      OP_NOR:  logic_res = ~(reg1_i | reg2_i);
      default: logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      OP_SLL:  shift_res = reg2_i << sh;
      OP_SRL:  shift_res = reg2_i >> sh;
      OP_SRA:  shift_res = $unsigned($signed(reg2_i) >>> sh);
      default: shift_res = '0;
    endcase
  end

  always_comb begin
    arith_res = '0;
    case (aluop_i)
      OP_ADDU: arith_res = reg1_i + reg2_i;
      OP_SUBU: arith_res = reg1_i - reg2_i;
      OP_SLT:  arith_res = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
      OP_SLTU: arith_res = {31'b0, reg1_i < reg2_i};
      default: arith_res = '0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      (alusel_i == SEL_LOGIC): alu_res = logic_res;
      (alusel_i == SEL_SHIFT): alu_res = shift_res;
      (alusel_i == SEL_ARITH): alu_res = arith_res;
      default:                 alu_res = '0;
    endcase
  end

  div_state_t  st_q, st_d;
  logic [CW-1:0] cnt_q;
  logic [31:0] dvs_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic        qneg_q;
  logic        rneg_q;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  assign dvd_mag = (is_sdiv && reg1_i[31]) ? -reg1_i : reg1_i;
  assign dvs_mag = (is_sdiv && reg2_i[31]) ? -reg2_i : reg2_i;
  assign rem_sh  = {rem_q, quo_q[31]};
  assign diff    = rem_sh - {1'b0, dvs_q};

  always_comb begin
    st_d = st_q;
    if (annul_i) begin
      st_d = S_IDLE;
    end else begin
      case (st_q)
        S_IDLE: begin
          if (is_div)
            st_d = (reg2_i == '0) ? S_DIVZERO : S_ON;
        end
        S_DIVZERO: st_d = S_DONE;
        S_ON: begin
          if (cnt_q == CW'(DIV_CYCLES - 1))
            st_d = S_DONE;
        end
        S_DONE:  st_d = S_IDLE;
        default: st_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (st_q == S_IDLE && st_d == S_ON) begin
        cnt_q  <= '0;
        dvs_q  <= dvs_mag;
        quo_q  <= dvd_mag;
        rem_q  <= '0;
        qneg_q <= is_sdiv && (reg1_i[31] ^ reg2_i[31]);
        rneg_q <= is_sdiv && reg1_i[31];
      end else if (st_q == S_IDLE && st_d == S_DIVZERO) begin
        quo_q  <= '0;
        rem_q  <= '0;
        qneg_q <= 1'b0;
        rneg_q <= 1'b0;
      end else if (st_q == S_ON && !annul_i) begin
        // restoring step: keep the trial difference only if no borrow
        cnt_q <= cnt_q + 1'b1;
        if (!diff[32]) begin
          rem_q <= diff[31:0];
          quo_q <= {quo_q[30:0], 1'b1};
        end else begin
          rem_q <= rem_sh[31:0];
          quo_q <= {quo_q[30:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o    = wd_i;
      wreg_o  = wreg_i && !is_div;
      wdata_o = is_div ? '0 : alu_res;
      case (st_q)
        S_IDLE:    stallreq_o = is_div && !annul_i;
        S_DIVZERO: stallreq_o = !annul_i;
        S_ON:      stallreq_o = !annul_i;
        S_DONE: begin
          if (!annul_i) begin
            whilo_o = 1'b1;
            lo_o    = qneg_q ? -quo_q : quo_q;
            hi_o    = rneg_q ? -rem_q : rem_q;
          end
        end
        default: stallreq_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed and random checks of ex_stage against a behavioural
// ALU/divider model and the stall/HI-LO timing of the divider.
module tb_ex_stage;

  localparam logic [7:0] OP_NOP  = 8'b00000000;
  localparam logic [7:0] OP_AND  = 8'b00100100;
  localparam logic [7:0] OP_OR   = 8'b00100101;
  localparam logic [7:0] OP_XOR  = 8'b00100110;
  localparam logic [7:0] OP_NOR  = 8'b00100111;
  localparam logic [7:0] OP_SLL  = 8'b01111100;
  localparam logic [7:0] OP_SRL  = 8'b00000010;
  localparam logic [7:0] OP_SRA  = 8'b00000011;
  localparam logic [7:0] OP_ADDU = 8'b00100001;
  localparam logic [7:0] OP_SUBU = 8'b00100011;
  localparam logic [7:0] OP_SLT  = 8'b00101010;
  localparam logic [7:0] OP_SLTU = 8'b00101011;
  localparam logic [7:0] OP_DIV  = 8'b00011010;
  localparam logic [7:0] OP_DIVU = 8'b00011011;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        annul_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .annul_i    (annul_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] sel,
    input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    logic [31:0] r;
    s = int'(a[4:0]);
    r = 32'd0;
    if (sel == SEL_LOGIC) begin
      if (op == OP_AND) r = a & b;
      if (op == OP_OR)  r = a | b;
      if (op == OP_XOR) r = a ^ b;
      if (op == OP_NOR) r = ~(a | b);
    end else if (sel == SEL_SHIFT) begin
      if (op == OP_SLL) r = 32'(longint'(b) * (longint'(1) << s));
      if (op == OP_SRL) r = 32'(longint'(b) / (longint'(1) << s));
      if (op == OP_SRA) begin
        longint sb;
        sb = longint'($signed(b));
        // arithmetic shift is floor division by 2^s
        if (sb < 0)
          r = 32'(-((-sb + (longint'(1) << s) - 1) / (longint'(1) << s)));
        else
          r = 32'(sb / (longint'(1) << s));
      end
    end else if (sel == SEL_ARITH) begin
      if (op == OP_ADDU) r = 32'(longint'(a) + longint'(b));
      if (op == OP_SUBU) r = 32'(longint'(a) - longint'(b));
      if (op == OP_SLT)
        r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      if (op == OP_SLTU)
        r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
    end
    return r;
  endfunction

  task automatic drive(input logic [2:0] sel, input logic [7:0] op,
    input logic [31:0] a, input logic [31:0] b,
    input logic [4:0] wd, input logic wr);
    alusel_i = sel;
    aluop_i  = op;
    reg1_i   = a;
    reg2_i   = b;
    wd_i     = wd;
    wreg_i   = wr;
  endtask

  task automatic comb_case(input string tag, input logic [2:0] sel,
    input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
    input logic [4:0] wd, input logic wr);
    drive(sel, op, a, b, wd, wr);
    settle();
    chk({tag, "_wdata"}, wdata_o, ref_alu(sel, op, a, b));
    chk({tag, "_wd"}, 32'(wd_o), 32'(wd));
    chk({tag, "_wreg"}, 32'(wreg_o), 32'(wr));
    tick();
  endtask

  task automatic run_div(input string tag, input bit sgn,
    input logic [31:0] a, input logic [31:0] b, input bit scramble);
    int lat;
    longint sa, sb, q, r;
    logic [31:0] eq, er;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    if (sb == 0) begin
      q = 0;
      r = 0;
      lat = 2;
    end else begin
      q = sa / sb;
      r = sa % sb;
      lat = 33;
    end
    eq = 32'(q);
    er = 32'(r);
    for (int c = 0; c <= lat + 1; c++) begin
      if (c < lat) begin
        if (c == 0 || !scramble)
          drive(SEL_ARITH, sgn ? OP_DIV : OP_DIVU, a, b, 5'd7, 1'b1);
        else
          drive(SEL_ARITH, sgn ? OP_DIV : OP_DIVU, $urandom, $urandom,
                5'd7, 1'b1);
      end else begin
        drive(SEL_NOP, OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      end
      settle();
      chk({tag, "_stall"}, 32'(stallreq_o), (c < lat) ? 32'd1 : 32'd0);
      chk({tag, "_whilo"}, 32'(whilo_o), (c == lat) ? 32'd1 : 32'd0);
      chk({tag, "_lo"}, lo_o, (c == lat) ? eq : 32'd0);
      chk({tag, "_hi"}, hi_o, (c == lat) ? er : 32'd0);
      if (c < lat) begin
        chk({tag, "_wreg"}, 32'(wreg_o), 32'd0);
        chk({tag, "_wdata"}, wdata_o, 32'd0);
      end
      tick();
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      drive(SEL_NOP, OP_NOP, $urandom, $urandom, 5'd0, 1'b0);
      settle();
      chk({tag, "_stall"}, 32'(stallreq_o), 32'd0);
      chk({tag, "_whilo"}, 32'(whilo_o), 32'd0);
      tick();
    end
  endtask

  logic [2:0] sel_tab[14];
  logic [7:0] op_tab[14];

  initial begin
    sel_tab = '{SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_SHIFT,
                SEL_SHIFT, SEL_SHIFT, SEL_ARITH, SEL_ARITH, SEL_ARITH,
                SEL_ARITH, SEL_LOGIC, SEL_NOP, SEL_ARITH};
    op_tab  = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU, 8'hFF, OP_OR, OP_SLL};
    rst     = 1'b1;
    annul_i = 1'b0;
    drive(SEL_LOGIC, OP_OR, 32'h1234, 32'h8001, 5'd5, 1'b1);
    tick();
    settle();
    chk("rst_wd", 32'(wd_o), 32'd0);
    chk("rst_wreg", 32'(wreg_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_whilo", 32'(whilo_o), 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    tick();
    rst = 1'b0;

    drive(SEL_LOGIC, OP_OR, 32'h0000F0F0, 32'h00000F0F, 5'd3, 1'b1);
    settle();
    chk("ori_wdata", wdata_o, 32'h0000FFFF);
    chk("ori_wd", 32'(wd_o), 32'd3);
    chk("ori_wreg", 32'(wreg_o), 32'd1);
    tick();
    drive(SEL_SHIFT, OP_SRA, 32'd4, 32'h80000010, 5'd4, 1'b1);
    settle();
    chk("sra", wdata_o, 32'hF8000001);
    tick();
    drive(SEL_ARITH, OP_SLT, 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1);
    settle();
    chk("slt", wdata_o, 32'd1);
    tick();
    drive(SEL_ARITH, OP_SLTU, 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1);
    settle();
    chk("sltu", wdata_o, 32'd0);
    tick();

    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 13);
      comb_case("rnd_alu", sel_tab[k], op_tab[k], $urandom, $urandom,
                5'($urandom), 1'($urandom));
    end

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b1);
    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    run_div("div_5_0", 1'b1, 32'd5, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20))
                                      : 32'($urandom);
      if ($urandom_range(0, 1) == 1) b = -b;
      run_div("rnd_div", 1'($urandom), $urandom, b, 1'b1);
    end

    for (int c = 0; c < 10; c++) begin
      drive(SEL_ARITH, OP_DIVU, 32'd1000, 32'd3, 5'd1, 1'b1);
      tick();
    end
    annul_i = 1'b1;
    settle();
    chk("annul_stall", 32'(stallreq_o), 32'd0);
    chk("annul_whilo", 32'(whilo_o), 32'd0);
    tick();
    annul_i = 1'b0;
    idle_check("post_annul", 30);

    annul_i = 1'b1;
    drive(SEL_ARITH, OP_DIV, 32'd50, 32'd5, 5'd1, 1'b1);
    settle();
    chk("annul_idle_stall", 32'(stallreq_o), 32'd0);
    tick();
    annul_i = 1'b0;
    idle_check("annul_idle", 40);
    run_div("divu_after_annul", 1'b0, 32'd9, 32'd3, 1'b0);

    for (int c = 0; c < 20; c++) begin
      drive(SEL_ARITH, OP_DIVU, 32'd12345, 32'd17, 5'd1, 1'b1);
      tick();
    end
    rst = 1'b1;
    drive(SEL_ARITH, OP_DIVU, 32'd12345, 32'd17, 5'd9, 1'b1);
    settle();
    chk("midrst_wd", 32'(wd_o), 32'd0);
    chk("midrst_stall", 32'(stallreq_o), 32'd0);
    chk("midrst_whilo", 32'(whilo_o), 32'd0);
    tick();
    rst = 1'b0;
    idle_check("post_rst", 20);
    run_div("divu_after_rst", 1'b0, 32'd9, 32'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
